// File: rtl/arb3_rr.sv
// Three-requester round-robin arbiter with ownership held until the owner releases its request.
// Optional watchdog (define ARB3_TIMEOUT_EN) revokes a grant after MAX_HOLD cycles.
module arb3_rr #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       any_req,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q;
  logic [2:0] grant_q;
  logic [1:0] gnt_id_q;
  logic [1:0] last_q;
  logic       busy_q;
  logic [1:0] win_id;

`ifdef ARB3_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HoldSat  = '1;
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;
`endif

  assign any_req = req[0] | req[1] | req[2];

  // Search starts just after the last owner, so the last owner has lowest priority.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    win_id = last_q;
    idx    = last_q;
    found  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && req[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      gnt_id_q  <= 2'd0;
      last_q    <= 2'd2;
      busy_q    <= 1'b0;
`ifdef ARB3_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB3_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= GRANT;
            grant_q  <= 3'b001 << win_id;
            gnt_id_q <= win_id;
            last_q   <= win_id;
            busy_q   <= 1'b1;
`ifdef ARB3_TIMEOUT_EN
            hold_q   <= '0;
`endif
          end
        end
        GRANT: begin
          // A release always wins over a watchdog expiry on the same edge.
          if (!req[gnt_id_q]) begin
            state_q  <= IDLE;
            grant_q  <= 3'b000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
          end
`ifdef ARB3_TIMEOUT_EN
          else if (hold_q == HoldLast) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            gnt_id_q  <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (hold_q != HoldSat) begin
            hold_q <= hold_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant  = grant_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

`ifdef ARB3_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
